muldiv: RTL
===========

# muldiv

Multi-cycle RV64M multiply/divide unit in the execute stage, alongside the single-cycle combinational ALU. Execute hands it operands and an M-extension function over a valid/ready handshake. It holds the operation for a fixed number of iterations and returns one 64-bit result over a second valid/ready handshake. Execute stalls while the unit is busy. A pipeline flush aborts the operation in flight.

## Interface
Parameters:
- `ITER`, default 64: iterations per full-width operation. This must equal the operand width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  abort any operation and drop any pending result.
- `in_valid`  in  1  operands and function are presented.
- `in_ready`  out  1  unit can accept an operation.
- `a`  in  64  operand rs1, type `u64`.
- `b`  in  64  operand rs2, type `u64`.
- `func`  in  4  operation, type `mdfunc_t`.
- `out_valid`  out  1  result is available.
- `out_ready`  in  1  consumer takes the result.
- `c`  out  64  result, type `u64`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - BUSY: iterating; `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `c` stable.
- Acceptance:
  - An operation is accepted on an edge where `in_valid & in_ready & ~flush`.
  - `a`, `b` and `func` are registered; upstream may change them after that edge.
- Functions:
  - MD_MUL: low 64 bits of a*b.
  - MD_DIV, MD_REM: signed quotient and remainder; remainder takes the sign of the dividend.
  - MD_DIVU, MD_REMU: unsigned quotient and remainder.
- Multiply: radix-2 shift-add over `ITER` iterations.
- Divide:
  - Magnitudes are taken at accept time.
  - Unsigned restoring division runs over `ITER` iterations.
  - Signs are fixed up when entering DONE.
- Special cases (division only) are resolved at accept and go straight to DONE on the next edge without iterating:
  - b==0: quotient is all ones (0xFFFF_FFFF_FFFF_FFFF); remainder is `a`.
  - Signed a==0x8000_0000_0000_0000 and b==-1: quotient is `a`; remainder is 0.
- DONE to IDLE: on an edge with `out_ready`. In IDLE a new operation may then be accepted the following cycle, not on the same edge.
- Flush:
  - From any state, `flush` forces IDLE on the next edge.
  - The counter and result are discarded, and `out_valid` is low from that edge.
  - Flush on the same edge as `in_valid` means nothing is accepted.
- Counter: the iteration counter is `$clog2(ITER)+1` bits wide and counts 0 to `ITER`-1. The terminal count moves BUSY to DONE.

## Timing
- Reset values (async assert): state IDLE, `in_ready`=1, `out_valid`=0, `c`=0, counter 0, all datapath registers 0.
- Latency:
  - Normal operation: `out_valid` rises exactly `ITER`+1 edges after the accept edge (ITER iterations plus one sign-fix/writeback edge).
  - Special-case division: 1 edge.
- `in_ready` is a registered function of state only; it has no combinational path from `in_valid`.
- `out_valid` and `c` are registers; neither has a combinational path from inputs.
- Throughput: at most one operation per `ITER`+2 cycles.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.

## Configuration
- `MULDIV_WORD_EN`:
  - Defined: adds MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW and MD_REMUW to `mdfunc_t`.
  - These operate on `a[31:0]` and `b[31:0]` and run `ITER/2` iterations, so latency is `ITER/2`+1.
  - The 32-bit result is sign-extended to 64.
  - Special cases use 32-bit values: x/0 gives quotient 0xFFFF_FFFF_FFFF_FFFF and remainder sext(a[31:0]); signed overflow uses 0x8000_0000.
- Not defined: the word functions do not exist, and `func` decodes only the five 64-bit operations.

## Structure
- The `pipes` package holds:
  - `mdfunc_t` (4-bit enum, MD_MUL=0 upward; word entries under the macro).
  - The muldiv state enum.
- `u64` comes from `common`.
- One sub-module, `divider`: iterative restoring unsigned divider with start/done, operand width as a parameter.
  - `muldiv` owns the handshake, the FSM, the multiplier, sign handling and special cases.

## Test plan
- Multiply with overflowing product:
  - Stimulus: MD_MUL, a=0x1_0000_0003, b=0x1_0000_0005.
  - Required: `c`=0x8_0000_000F, `out_valid` exactly 65 edges after accept.
- Signed division with negative dividend:
  - Stimulus: MD_DIV a=-7, b=2, then MD_REM a=-7, b=2.
  - Required: quotient `c`=-3 (0xFFFF_FFFF_FFFF_FFFD), remainder `c`=-1.
- Division by zero:
  - Stimulus: MD_DIVU a=5, b=0, then MD_REMU a=5, b=0.
  - Required: 0xFFFF_FFFF_FFFF_FFFF, then 5, each with `out_valid` 1 edge after accept.
- Signed overflow:
  - Stimulus: MD_DIV a=0x8000_0000_0000_0000, b=-1.
  - Required: `c`=0x8000_0000_0000_0000; MD_REM with the same operands gives 0.
- Backpressure, then flush:
  - Stimulus: hold `out_ready`=0 for 10 cycles in DONE, then assert `flush` on cycle 30 of a new BUSY operation.
  - Required: `c` stays stable throughout the hold; after the flush `out_valid` never rises and `in_ready`=1 one edge later.
- Word operation (with `MULDIV_WORD_EN` only):
  - Stimulus: MD_MULW, a=0x7FFF_FFFF, b=2.
  - Required: `c`=0xFFFF_FFFF_FFFF_FFFE after 33 edges.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the RV64M multiply/divide unit.
// Defining MULDIV_WORD_EN adds the RV64 word (W-suffix) functions.
package common;
  typedef logic [63:0] u64;
endpackage

package pipes;
  import common::*;

  typedef enum logic [3:0] {
    MD_MUL  = 4'd0,
    MD_DIV  = 4'd1,
    MD_DIVU = 4'd2,
    MD_REM  = 4'd3,
    MD_REMU = 4'd4
`ifdef MULDIV_WORD_EN
    ,
    MD_MULW  = 4'd5,
    MD_DIVW  = 4'd6,
    MD_DIVUW = 4'd7,
    MD_REMW  = 4'd8,
    MD_REMUW = 4'd9
`endif
  } mdfunc_t;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  // Per-operation control bits, decoded once at accept and held while busy.
  typedef struct packed {
    logic mul;
    logic rem;
    logic sgn;
    logic word;
  } md_dec_t;

  function automatic md_dec_t md_decode(mdfunc_t f);
    md_dec_t d;
    d = '0;
    case (f)
      MD_DIV:   d.sgn = 1'b1;
      MD_DIVU:  d = '0;
      MD_REM:   begin d.rem = 1'b1; d.sgn = 1'b1; end
      MD_REMU:  d.rem = 1'b1;
`ifdef MULDIV_WORD_EN
      MD_MULW:  begin d.mul = 1'b1; d.word = 1'b1; end
      MD_DIVW:  begin d.sgn = 1'b1; d.word = 1'b1; end
      MD_DIVUW: d.word = 1'b1;
      MD_REMW:  begin d.rem = 1'b1; d.sgn = 1'b1; d.word = 1'b1; end
      MD_REMUW: begin d.rem = 1'b1; d.word = 1'b1; end
`endif
      default:  d.mul = 1'b1;
    endcase
    return d;
  endfunction

  function automatic u64 sext32(logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction
endpackage

// File: rtl/divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, len bits per operation.
module divider #(
  parameter int W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  input  logic [$clog2(W):0] len,
  output logic [W-1:0]     quo,
  output logic [W-1:0]     rem,
  output logic             done
);
  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0] cnt, lim;
  logic [W-1:0]  dsr;
  logic [W:0]    trial, diff;

  assign trial = {rem, quo[W-1]};
  assign diff  = trial - {1'b0, dsr};
  assign done  = (cnt == lim);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
      lim <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      cnt <= '0;
      lim <= len;
    end else if (!done) begin
      cnt <= cnt + 1'b1;
      if (diff[W]) begin
        rem <= trial[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end else begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end
    end
  end
endmodule

// File: rtl/muldiv.sv
// Multi-cycle RV64M multiply/divide unit with valid/ready in and out and flush abort.
// Word functions are present only when MULDIV_WORD_EN is defined.
module muldiv
  import common::*;
  import pipes::*;
#(
  parameter int ITER = 64
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    flush,
  input  logic    in_valid,
  output logic    in_ready,
  input  u64      a,
  input  u64      b,
  input  mdfunc_t func,
  output logic    out_valid,
  input  logic    out_ready,
  output u64      c
);
  localparam int            CW   = $clog2(ITER) + 1;
  localparam logic [CW-1:0] FULL = CW'(ITER);
  localparam logic [CW-1:0] HALF = CW'(ITER / 2);

  md_state_t     state;
  md_dec_t       dec, op;
  logic [CW-1:0] cnt, len;
  logic          special, neg_q, neg_r;
  u64            mcand, mplier, acc;

  logic    accept, a_neg, b_neg, b_zero, ovf, special_c, div_done, finish;
  u64      a_ext, b_ext, a_mag, b_mag, div_a, min_val, spec_val;
  u64      div_quo, div_rem, q_fix, r_fix, raw, result;

  // Operand conditioning at accept: width/sign extension, magnitudes, special cases.
  assign dec    = md_decode(func);
  assign accept = (state == MD_IDLE) & in_valid & ~flush;
  assign a_ext  = !dec.word ? a : (dec.sgn ? sext32(a[31:0]) : {32'b0, a[31:0]});
  assign b_ext  = !dec.word ? b : (dec.sgn ? sext32(b[31:0]) : {32'b0, b[31:0]});
  assign a_neg  = dec.sgn & a_ext[63];
  assign b_neg  = dec.sgn & b_ext[63];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;
  // Word dividends sit in the upper half so ITER/2 steps leave the quotient in quo[31:0].
  assign div_a  = dec.word ? (a_mag << (ITER / 2)) : a_mag;

  assign min_val   = dec.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign b_zero    = (b_ext == '0);
  assign ovf       = dec.sgn & (a_ext == min_val) & (b_ext == '1);
  assign special_c = ~dec.mul & (b_zero | ovf);
  assign spec_val  = b_zero ? (dec.rem ? (dec.word ? sext32(a[31:0]) : a) : '1)
                            : (dec.rem ? '0 : a_ext);

  divider #(.W(ITER)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (accept),
    .dividend (div_a),
    .divisor  (b_mag),
    .len      (dec.word ? HALF : FULL),
    .quo      (div_quo),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Writeback: sign fix for division, then sign-extend word results.
  assign q_fix  = neg_q ? -div_quo : div_quo;
  assign r_fix  = neg_r ? -div_rem : div_rem;
  assign raw    = op.mul ? acc : (op.rem ? r_fix : q_fix);
  assign result = op.word ? sext32(raw[31:0]) : raw;
  // cnt runs 0..len-1 while iterating; reaching len marks the writeback edge.
  assign finish = special | ((cnt == len) & (op.mul | div_done));

  // NOTE: datapath registers are reset as well, so c and the operand copies read 0, never X, after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= MD_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      cnt       <= '0;
      len       <= '0;
      op        <= '0;
      special   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else if (flush) begin
      state     <= MD_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      cnt       <= '0;
      special   <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (in_valid) begin
            state    <= MD_BUSY;
            in_ready <= 1'b0;
            op       <= dec;
            cnt      <= '0;
            len      <= dec.word ? HALF : FULL;
            special  <= special_c;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            mcand    <= a_ext;
            mplier   <= b_ext;
            acc      <= special_c ? spec_val : '0;
          end
        end
        MD_BUSY: begin
          if (finish) begin
            state     <= MD_DONE;
            out_valid <= 1'b1;
            c         <= special ? acc : result;
          end else begin
            cnt <= cnt + 1'b1;
            if (op.mul) begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            state     <= MD_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= MD_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
